// File: rtl/rr_arb8_ctrl_pkg.sv
// Shared constants and state encoding for the 8-way round-robin arbiter.
`default_nettype none
package rr_arb8_ctrl_pkg;
  localparam int N_REQ            = 8;
  localparam int IDX_W            = 3;
  localparam int DEFAULT_MAX_HOLD = 16;
  localparam int DEFAULT_CNT_W    = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;
endpackage
`default_nettype wire

// File: rtl/rr_arb8_ctrl_pick8.sv
// Rotated priority encoder: first set bit of (req & ~mask) at or after ptr, wrapping 7->0.
`default_nettype none
module rr_pick8
  import rr_arb8_ctrl_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] mask,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             found
);
  logic [N_REQ-1:0]   avail;
  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [IDX_W-1:0]   offs;

  always_comb begin
    avail = req & ~mask;
    // Doubling the vector lets a plain right shift act as a rotate by ptr.
    dbl   = {avail, avail};
    rot   = dbl[ptr +: N_REQ];
    found = 1'b0;
    offs  = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        found = 1'b1;
        offs  = IDX_W'(i);
      end
    end
    idx = ptr + offs;
  end
endmodule
`default_nettype wire

// File: rtl/rr_arb8_ctrl.sv
// Round-robin arbiter for 8 requesters with registered grant and hold-time preemption.
`default_nettype none
module rr_arb8_ctrl
  import rr_arb8_ctrl_pkg::*;
#(
  parameter int MAX_HOLD = DEFAULT_MAX_HOLD,
  parameter int CNT_W    = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx,
  output logic [N_REQ-1:0] gnt_onehot,
  output logic             preempt,
  output logic [CNT_W-1:0] busy_cnt
);
  state_t           state, state_n;
  logic [IDX_W-1:0] ptr, ptr_n;
  logic [IDX_W-1:0] idx_n;
  logic [N_REQ-1:0] onehot_n;
  logic [CNT_W-1:0] cnt_n;
  logic             preempt_n;

  logic [N_REQ-1:0] pick_mask;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;
  logic             owner_req;
  logic             limit_hit;

  // In GRANT the owner is always masked: the pick is only used on release or preemption.
  assign pick_mask = (state == GRANT) ? gnt_onehot : '0;

  rr_pick8 u_pick (
    .req   (req),
    .mask  (pick_mask),
    .ptr   (ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign owner_req = req[gnt_idx];
  assign limit_hit = (MAX_HOLD != 0) && (busy_cnt == CNT_W'(MAX_HOLD))
                     && owner_req && pick_found;

  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    idx_n     = gnt_idx;
    cnt_n     = busy_cnt;
    preempt_n = 1'b0;
    case (state)
      IDLE: begin
        if (pick_found) begin
          state_n = GRANT;
          idx_n   = pick_idx;
          ptr_n   = pick_idx + IDX_W'(1);
          cnt_n   = CNT_W'(1);
        end
      end
      GRANT: begin
        if (!owner_req) begin
          if (pick_found) begin
            idx_n = pick_idx;
            ptr_n = pick_idx + IDX_W'(1);
            cnt_n = CNT_W'(1);
          end else begin
            state_n = IDLE;
            cnt_n   = '0;
          end
        end else if (limit_hit) begin
          idx_n     = pick_idx;
          ptr_n     = pick_idx + IDX_W'(1);
          cnt_n     = CNT_W'(1);
          preempt_n = 1'b1;
        end else if (busy_cnt != '1) begin
          cnt_n = busy_cnt + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
    onehot_n = (state_n == GRANT) ? (N_REQ'(1) << idx_n) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= '0;
      gnt_idx    <= '0;
      gnt_onehot <= '0;
      busy_cnt   <= '0;
      preempt    <= 1'b0;
    end else begin
      state      <= state_n;
      ptr        <= ptr_n;
      gnt_idx    <= idx_n;
      gnt_onehot <= onehot_n;
      busy_cnt   <= cnt_n;
      preempt    <= preempt_n;
    end
  end

  assign gnt_valid = (state == GRANT);
endmodule
`default_nettype wire

// File: tb/tb_rr_arb8_ctrl.sv
// Directed, table-driven bench for rr_pick8 and rr_arb8_ctrl (MAX_HOLD 16 and 4).
`default_nettype none
module tb_rr_arb8_ctrl;
  logic       clk = 1'b0;
  logic       rst_n, rst4_n;
  logic [7:0] req, req4;
  logic       v0, v4, p0, p4;
  logic [2:0] i0, i4;
  logic [7:0] oh0, oh4;
  logic [4:0] c0, c4;

  logic [7:0] pk_req, pk_mask;
  logic [2:0] pk_ptr, pk_idx;
  logic       pk_found;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rr_arb8_ctrl #(.MAX_HOLD(16), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt_valid(v0), .gnt_idx(i0),
    .gnt_onehot(oh0), .preempt(p0), .busy_cnt(c0)
  );

  rr_arb8_ctrl #(.MAX_HOLD(4), .CNT_W(5)) dut4 (
    .clk(clk), .rst_n(rst4_n), .req(req4), .gnt_valid(v4), .gnt_idx(i4),
    .gnt_onehot(oh4), .preempt(p4), .busy_cnt(c4)
  );

  rr_pick8 u_pick (
    .req(pk_req), .mask(pk_mask), .ptr(pk_ptr), .idx(pk_idx), .found(pk_found)
  );

  typedef struct {
    logic [7:0] req;
    logic [7:0] mask;
    logic [2:0] ptr;
    logic [2:0] idx;
    logic       found;
  } pick_vec_t;

  typedef struct {
    logic       sel;
    logic [7:0] req;
    logic       v;
    logic [2:0] idx;
    logic [4:0] cnt;
    logic       p;
  } arb_vec_t;

  function automatic arb_vec_t mk(logic s, logic [7:0] r, logic v, logic [2:0] ix,
                                  logic [4:0] c, logic p);
    arb_vec_t a;
    a.sel = s; a.req = r; a.v = v; a.idx = ix; a.cnt = c; a.p = p;
    return a;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Compares the full output set of one arbiter instance against expectations.
  task automatic chk_arb(input string name, input logic s, input logic v, input logic [2:0] ix,
                         input logic [4:0] c, input logic p);
    logic [7:0] exp_oh;
    exp_oh = v ? (8'h01 << ix) : 8'h00;
    chk({name, ".valid"}, s ? v4 : v0, v);
    if (v) chk({name, ".idx"}, s ? i4 : i0, ix);
    chk({name, ".onehot"}, s ? oh4 : oh0, exp_oh);
    chk({name, ".cnt"}, s ? c4 : c0, c);
    chk({name, ".preempt"}, s ? p4 : p0, p);
  endtask

  task automatic step(input logic s, input logic [7:0] r);
    if (s) req4 = r; else req = r;
    @(posedge clk);
    #1;
  endtask

  pick_vec_t pv[10];
  arb_vec_t  av[24];
  int        n_av;

  initial begin
    rst_n = 1'b0; rst4_n = 1'b0; req = 8'hFF; req4 = 8'h00;
    pk_req = '0; pk_mask = '0; pk_ptr = '0;

    // Unit vectors for the rotated priority encoder.
    pv[0] = '{8'h00, 8'h00, 3'd0, 3'd0, 1'b0};
    pv[1] = '{8'hFF, 8'h00, 3'd0, 3'd0, 1'b1};
    pv[2] = '{8'hFF, 8'h00, 3'd5, 3'd5, 1'b1};
    pv[3] = '{8'h01, 8'h00, 3'd7, 3'd0, 1'b1};
    pv[4] = '{8'h81, 8'h00, 3'd1, 3'd7, 1'b1};
    pv[5] = '{8'h0C, 8'h04, 3'd0, 3'd3, 1'b1};
    pv[6] = '{8'h10, 8'h10, 3'd2, 3'd0, 1'b0};
    pv[7] = '{8'h41, 8'h00, 3'd7, 3'd0, 1'b1};
    pv[8] = '{8'h44, 8'h00, 3'd3, 3'd6, 1'b1};
    pv[9] = '{8'h22, 8'h02, 3'd6, 3'd5, 1'b1};
    for (int k = 0; k < 10; k++) begin
      pk_req = pv[k].req; pk_mask = pv[k].mask; pk_ptr = pv[k].ptr;
      #1;
      chk($sformatf("pick%0d.found", k), pk_found, pv[k].found);
      if (pv[k].found) chk($sformatf("pick%0d.idx", k), pk_idx, pv[k].idx);
    end

    // Single requester, then an idle gap, then requester 0 (MAX_HOLD=16).
    n_av = 0;
    for (int k = 1; k <= 5; k++) av[n_av++] = mk(1'b0, 8'h10, 1'b1, 3'd4, 5'(k), 1'b0);
    av[n_av++] = mk(1'b0, 8'h00, 1'b0, 3'd0, 5'd0, 1'b0);
    av[n_av++] = mk(1'b0, 8'h01, 1'b1, 3'd0, 5'd1, 1'b0);
    av[n_av++] = mk(1'b0, 8'h00, 1'b0, 3'd0, 5'd0, 1'b0);
    // MAX_HOLD=4 preemption ping-pong, then simultaneous release and limit.
    for (int k = 1; k <= 4; k++) av[n_av++] = mk(1'b1, 8'h0C, 1'b1, 3'd2, 5'(k), 1'b0);
    av[n_av++] = mk(1'b1, 8'h0C, 1'b1, 3'd3, 5'd1, 1'b1);
    for (int k = 2; k <= 4; k++) av[n_av++] = mk(1'b1, 8'h0C, 1'b1, 3'd3, 5'(k), 1'b0);
    av[n_av++] = mk(1'b1, 8'h0C, 1'b1, 3'd2, 5'd1, 1'b1);
    for (int k = 2; k <= 4; k++) av[n_av++] = mk(1'b1, 8'h0C, 1'b1, 3'd2, 5'(k), 1'b0);
    av[n_av++] = mk(1'b1, 8'h08, 1'b1, 3'd3, 5'd1, 1'b0);
    av[n_av++] = mk(1'b1, 8'h00, 1'b0, 3'd0, 5'd0, 1'b0);

    // Reset asserted with all requesting: outputs clear immediately and stay clear.
    #1;
    chk_arb("rst_async", 1'b0, 1'b0, 3'd0, 5'd0, 1'b0);
    chk("rst_async.idx", i0, 3'd0);
    @(posedge clk); #1;
    chk_arb("rst_hold", 1'b0, 1'b0, 3'd0, 5'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1; rst4_n = 1'b1;
    @(posedge clk); #1;
    chk_arb("rst_first", 1'b0, 1'b1, 3'd0, 5'd1, 1'b0);

    // Round-robin with every owner releasing after two cycles: 0..7,0 back-to-back.
    for (int k = 0; k < 8; k++) begin
      logic [7:0] drop;
      step(1'b0, 8'hFF);
      chk_arb($sformatf("rr%0d.hold", k), 1'b0, 1'b1, 3'(k), 5'd2, 1'b0);
      drop = 8'hFF & ~(8'h01 << k);
      step(1'b0, drop);
      chk_arb($sformatf("rr%0d.next", k), 1'b0, 1'b1, 3'((k + 1) % 8), 5'd1, 1'b0);
      req = 8'hFF;
    end
    step(1'b0, 8'h00);
    chk_arb("rr_idle", 1'b0, 1'b0, 3'd0, 5'd0, 1'b0);

    for (int k = 0; k < n_av; k++) begin
      step(av[k].sel, av[k].req);
      chk_arb($sformatf("vec%0d", k), av[k].sel, av[k].v, av[k].idx, av[k].cnt, av[k].p);
    end

    // Lone requester past the limit: no preemption, counter saturates.
    for (int k = 1; k <= 40; k++) begin
      step(1'b1, 8'h20);
      chk_arb($sformatf("sat%0d", k), 1'b1, 1'b1, 3'd5, (k < 31) ? 5'(k) : 5'd31, 1'b0);
    end
    step(1'b1, 8'h00);

    // Asynchronous reset mid-grant; ptr must restart at 0.
    step(1'b0, 8'h40);
    chk_arb("mid_gnt", 1'b0, 1'b1, 3'd6, 5'd1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk_arb("mid_rst", 1'b0, 1'b0, 3'd0, 5'd0, 1'b0);
    chk("mid_rst.idx", i0, 3'd0);
    req = 8'h41;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 8'h41);
    chk_arb("post_rst", 1'b0, 1'b1, 3'd0, 5'd1, 1'b0);
    step(1'b0, 8'h04);
    chk_arb("pre_rst2", 1'b0, 1'b1, 3'd2, 5'd1, 1'b0);
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    step(1'b0, 8'h44);
    chk_arb("post_rst2", 1'b0, 1'b1, 3'd2, 5'd1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
